fifo_reader: RTL and testbench
==============================

# fifo_reader

Read-side controller for the 16-deep, 8-bit synchronous FIFO. It drives the FIFO's `rd` strobe, captures the FIFO's registered `dout` one cycle after each accepted read, and holds the words in a 3-entry skid buffer. Words leave on a valid/ready stream with packet framing (`m_last` every `PKT_LEN` beats). It sits between the FIFO and any downstream consumer, and sustains one word per cycle without a combinational path from `m_ready` to `fifo_rd`.

## Interface
- `DW`, 8: data width; must match the FIFO data width.
- `PKT_LEN`, 4: beats per packet, legal range 1..256. `m_last` marks the final beat of each packet.
- `clk`  in  1: rising-edge clock, shared with the FIFO.
- `rst`  in  1: reset, asynchronous, active-low.
- `en`  in  1: when low, no new FIFO reads are issued; reads already in flight complete and remain drainable.
- `fifo_empty`  in  1: FIFO `empty` flag.
- `fifo_full`  in  1: FIFO `full` flag.
- `fifo_wr`  in  1: FIFO `wr` strobe, observed for the write-priority rule.
- `fifo_dout`  in  DW: FIFO registered read data.
- `fifo_rd`  out  1: FIFO `rd` strobe.
- `m_valid`  out  1: stream data valid.
- `m_ready`  in  1: stream consumer ready.
- `m_data`  out  DW: stream data.
- `m_last`  out  1: last beat of a packet.
- `occ`  out  2: skid-buffer occupancy, 0..3.

## Operation
- Read acceptance: the FIFO gives writes priority. A read is accepted in a cycle only if all of the following hold:
  - `fifo_rd` is high;
  - `fifo_empty` is low;
  - `fifo_wr && !fifo_full` is false.
- `acc` is the internal flag for an accepted read. A suppressed read is not retried implicitly; the request logic simply re-evaluates in the next cycle.
- Request rule: `fifo_rd = en && !fifo_empty && (occ + pend) < 3`.
  - `pend` is a 1-bit register set by `acc` and cleared the following cycle.
  - `fifo_rd` depends only on registered state, `en` and `fifo_empty`.
- Capture: when `pend` is 1, `fifo_dout` is written into the buffer tail at the end of that cycle.
- Credit accounting guarantees buffer space for every capture. Overflow is unreachable; a bench assertion must flag it if it ever occurs.
- Pop: `m_valid && m_ready` removes the head entry. Capture and pop may occur in the same cycle.
  - Occupancy change = +capture − pop.
  - A pop from an empty buffer is impossible, because `m_valid` is low when empty.
- Ordering is strict FIFO. The buffer is a 3-entry circular array with 2-bit head and tail pointers that wrap 2→0.
- Stream rules:
  - `m_valid = (occ != 0)`; `m_data` = head entry.
  - While `m_valid && !m_ready`, `m_data` and `m_last` stay stable.
- Framing:
  - `beat` counter, width clog2(`PKT_LEN`) with a minimum of 1, increments on each pop.
  - The counter wraps to 0 on the pop at which `beat == PKT_LEN-1`.
  - `m_last = m_valid && (beat == PKT_LEN-1)`. With `PKT_LEN = 1`, `m_last = m_valid`.
- `en` deassertion mid-stream: the pending capture still completes and buffered words still drain. The `beat` count is preserved.

## Timing
- Reset (`rst` low, asynchronous): `pend = 0`, `occ = 0`, pointers = 0, `beat = 0`.
  - Outputs during reset: `fifo_rd = 0`, `m_valid = 0`, `m_last = 0`, `m_data = 0`.
  - Reset release takes effect at the first rising edge with `rst` high.
- The FIFO reset is separate and synchronous. A reader reset with the FIFO not empty causes no data loss in the FIFO. Any word pending or buffered inside the reader is discarded.
- Latency:
  - `acc` in cycle N; FIFO `dout` valid in N+1; word captured at the end of N+1.
  - `m_valid` goes high in N+2.
  - From FIFO non-empty with the reader idle, first `m_valid` appears 2 cycles after the first `acc`.
- Throughput: with `m_ready` held high, steady state is `occ = 1`, `pend = 1`, with one `acc` and one pop per cycle.
- Backpressure: with `m_ready` held low, at most 3 words are held (`occ = 3`, `pend = 0`) and `fifo_rd` goes low.
- Simultaneous events:
  - Capture and pop in the same cycle with `occ = 3` is legal; the result is `occ = 3`.
  - A FIFO write in the same cycle as a read suppresses the read (`acc = 0`, `pend` stays 0).

## Test plan
- Reset/idle: hold `rst` low with the FIFO loaded → `fifo_rd = 0`, `m_valid = 0`, `occ = 0`. After release with `en = 1`, `fifo_rd` goes high the next cycle.
- Streaming: load 8 words 0x10..0x17, `m_ready = 1` → words emerge in order, one per cycle, first `m_valid` 2 cycles after the first `acc`. With `PKT_LEN = 4`, `m_last` is high on 0x13 and 0x17.
- Backpressure: load 6 words, `m_ready = 0` for 10 cycles → `occ = 3`, `fifo_rd = 0`, `m_data = 0x10` stable. Release `m_ready` → 0x10..0x15 delivered with no loss or duplicates.
- Write-priority collision: FIFO holds 1 word, assert `fifo_wr` while `fifo_rd` is high → no capture that cycle. The word is read one cycle later, and the total delivered count equals the total written count.
- `en` toggle and reset mid-operation:
  - Drop `en` with `pend = 1` → that word is still delivered and no further `acc` occurs.
  - Pull `rst` low with `occ = 2` → `m_valid` drops immediately; after release, `beat` restarts at 0.
- Wrap and framing: stream 40 words with random `m_ready` → pointer wrap 2→0 is exercised, data matches a scoreboard, and `m_last` occurs exactly 10 times.

Source files
------------

// File: rtl/fifo_reader.sv
// Read-side controller for the 16x8 synchronous FIFO: credit-limited reads, capture of the
// registered dout into a 3-entry skid buffer, and a framed valid/ready output stream.
module fifo_reader #(
    parameter int DW      = 8,
    parameter int PKT_LEN = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          fifo_empty,
    input  logic          fifo_full,
    input  logic          fifo_wr,
    input  logic [DW-1:0] fifo_dout,
    output logic          fifo_rd,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic [1:0]    occ
);
    localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

    logic          run_q,  run_d;
    logic          pend_q, pend_d;
    logic [1:0]    occ_q,  occ_d;
    logic [1:0]    head_q, head_d;
    logic [1:0]    tail_q, tail_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [DW-1:0] mem_q [3];
    logic [DW-1:0] mem_d [3];
    logic          acc;
    logic          pop;
    logic [2:0]    credit;

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // run_q keeps fifo_rd low until the first clock edge after reset release.
    always_comb begin
        credit  = {1'b0, occ_q} + {2'b00, pend_q};
        fifo_rd = run_q && en && !fifo_empty && (credit < 3'd3);
        acc     = fifo_rd && !fifo_empty && !(fifo_wr && !fifo_full);
        m_valid = (occ_q != 2'd0);
        m_data  = mem_q[head_q];
        m_last  = m_valid && (beat_q == LAST_BEAT);
        occ     = occ_q;
        pop     = m_valid && m_ready;
    end

    always_comb begin
        run_d  = 1'b1;
        pend_d = acc;
        mem_d  = mem_q;
        tail_d = tail_q;
        head_d = head_q;
        beat_d = beat_q;
        occ_d  = occ_q + {1'b0, pend_q} - {1'b0, pop};
        if (pend_q) begin
            mem_d[tail_q] = fifo_dout;
            tail_d        = nxt(tail_q);
        end
        if (pop) begin
            head_d = nxt(head_q);
            beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + BW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q  <= 1'b0;
            pend_q <= 1'b0;
            occ_q  <= 2'd0;
            head_q <= 2'd0;
            tail_q <= 2'd0;
            beat_q <= '0;
            for (int i = 0; i < 3; i++) mem_q[i] <= '0;
        end else begin
            run_q  <= run_d;
            pend_q <= pend_d;
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
            beat_q <= beat_d;
            mem_q  <= mem_d;
        end
    end
endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: a queue-based FIFO model feeds the reader, a scoreboard queue holds
// every written word, and a negedge monitor checks data order and packet framing.
module tb_fifo_reader;
    localparam int DW      = 8;
    localparam int PKT_LEN = 4;

    logic          clk        = 1'b0;
    logic          rst        = 1'b0;
    logic          en         = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_full  = 1'b0;
    logic          fifo_wr    = 1'b0;
    logic [DW-1:0] wdata      = '0;
    logic [DW-1:0] fifo_dout  = '0;
    logic          m_ready    = 1'b0;
    logic          fifo_rd;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [1:0]    occ;

    int total = 0, bad = 0, cyc = 0, reads = 0, pops = 0, lasts = 0;
    int first_acc = -1, first_valid = -1, last_pop_cyc = -1, mbeat = 0;
    logic [DW-1:0] last_data = '0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] fq[$];

    fifo_reader #(.DW(DW), .PKT_LEN(PKT_LEN)) dut (
        .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .fifo_wr(fifo_wr), .fifo_dout(fifo_dout), .fifo_rd(fifo_rd), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .occ(occ)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // FIFO model: writes win over reads, dout registered on an accepted read.
    always @(posedge clk) begin
        if (fifo_wr && fq.size() < 16) fq.push_back(wdata);
        else if (fifo_rd && fq.size() > 0) begin
            fifo_dout <= fq.pop_front();
            reads++;
            if (first_acc < 0) first_acc = cyc;
        end
        fifo_empty <= (fq.size() == 0);
        fifo_full  <= (fq.size() == 16);
        cyc++;
    end

    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            mbeat      = 0;
            prev_stall = 1'b0;
        end else begin
            assert (!(dut.pend_q && dut.occ_q == 2'd3 && !(m_valid && m_ready)))
            else begin
                bad++;
                $display("FAIL overflow: capture into full buffer got occ=3 want space (cycle %0d)", cyc);
            end
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (prev_stall) begin
                check("stall_valid", int'(m_valid), 1);
                check("stall_data", int'(m_data), int'(prev_data));
                check("stall_last", int'(m_last), int'(prev_last));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_word: got %0d want none", m_data);
                end else begin
                    check("data", int'(m_data), int'(exp_q.pop_front()));
                    check("last", int'(m_last), int'(mbeat == PKT_LEN - 1));
                end
                mbeat = (mbeat == PKT_LEN - 1) ? 0 : mbeat + 1;
                pops++;
                last_pop_cyc = cyc;
                if (m_last) begin
                    lasts++;
                    last_data = m_data;
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic write_burst(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            fifo_wr = 1'b1;
            wdata   = base + DW'(i);
            exp_q.push_back(wdata);
        end
        @(posedge clk); #1;
        fifo_wr = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || fq.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, exp_q.size() + fq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int p0, r0, l0, b0, n, sent, lost, exp_last, coll;

        // Reset held with the FIFO loaded
        en = 1'b1;
        m_ready = 1'b1;
        write_burst(8'h10, 8);
        repeat (2) @(posedge clk);
        #1;
        check("rst_fifo_rd", int'(fifo_rd), 0);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_occ", int'(occ), 0);
        check("rst_m_last", int'(m_last), 0);
        check("rst_m_data", int'(m_data), 0);
        rst = 1'b1;
        check("rel_rd_before_edge", int'(fifo_rd), 0);
        @(posedge clk);
        @(negedge clk);
        check("rel_rd_after_edge", int'(fifo_rd), 1);
        wait_drain("stream_drain");
        check("stream_latency", first_valid - first_acc, 2);
        check("stream_rate", last_pop_cyc - first_valid, 7);
        check("stream_pops", pops, 8);
        check("stream_lasts", lasts, 2);
        check("stream_last_word", int'(last_data), 8'h17);

        // Backpressure
        m_ready = 1'b0;
        p0 = pops;
        write_burst(8'h10, 6);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("bp_occ", int'(occ), 3);
        check("bp_fifo_rd", int'(fifo_rd), 0);
        check("bp_valid", int'(m_valid), 1);
        check("bp_data", int'(m_data), 8'h10);
        @(posedge clk); #1;
        m_ready = 1'b1;
        wait_drain("bp_drain");
        check("bp_pops", pops - p0, 6);

        // Write-priority collision
        p0 = pops;
        @(posedge clk); #1;
        en = 1'b0; fifo_wr = 1'b1; wdata = 8'h20; exp_q.push_back(wdata);
        @(posedge clk); #1;
        en = 1'b1; fifo_wr = 1'b1; wdata = 8'h21; exp_q.push_back(wdata);
        coll = cyc;
        @(negedge clk);
        check("coll_rd_high", int'(fifo_rd), 1);
        @(posedge clk); #1;
        fifo_wr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("coll_cycle", cyc - coll, 2);
        check("coll_no_capture", int'(m_valid), 0);
        @(negedge clk);
        check("coll_late_capture", int'(m_valid), 1);
        wait_drain("coll_drain");
        check("coll_total", pops - p0, 2);

        // en dropped with a read in flight
        @(posedge clk); #1;
        en = 1'b0;
        write_burst(8'h30, 3);
        @(posedge clk); #1;
        en = 1'b1;
        r0 = reads;
        p0 = pops;
        @(posedge clk); #1;
        en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("en_off_rd", int'(fifo_rd), 0);
        end
        check("en_reads", reads - r0, 1);
        check("en_delivered", pops - p0, 1);
        @(posedge clk); #1;
        en = 1'b1;
        wait_drain("en_drain");

        // Reset with two words buffered
        m_ready = 1'b0;
        write_burst(8'h40, 3);
        n = 0;
        while (occ != 2'd2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rstmid_occ2", int'(occ), 2);
        #2 rst = 1'b0;
        #1;
        check("rstmid_valid", int'(m_valid), 0);
        check("rstmid_occ", int'(occ), 0);
        check("rstmid_rd", int'(fifo_rd), 0);
        lost = reads - pops;
        for (int i = 0; i < lost; i++) if (exp_q.size() > 0) void'(exp_q.pop_front());
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        m_ready = 1'b1;
        l0 = lasts;
        write_burst(8'h50, 4);
        wait_drain("post_rst_drain");
        check("post_rst_lasts", lasts - l0, 1);
        check("post_rst_last_word", int'(last_data), 8'h53);

        // 40 words with random backpressure
        b0 = mbeat;
        l0 = lasts;
        p0 = pops;
        n = 0;
        sent = 0;
        while (sent < 40 && n < 2000) begin
            @(posedge clk); #1;
            m_ready = 1'($urandom_range(0, 1));
            if (fq.size() < 15 && $urandom_range(0, 2) != 0) begin
                fifo_wr = 1'b1;
                wdata   = DW'(8'h60 + sent);
                exp_q.push_back(wdata);
                sent++;
            end else begin
                fifo_wr = 1'b0;
            end
            n++;
        end
        @(posedge clk); #1;
        fifo_wr = 1'b0;
        m_ready = 1'b1;
        wait_drain("wrap_drain");
        exp_last = 0;
        for (int i = 0; i < 40; i++) if ((b0 + i) % PKT_LEN == PKT_LEN - 1) exp_last++;
        check("wrap_sent", sent, 40);
        check("wrap_pops", pops - p0, 40);
        check("wrap_lasts", lasts - l0, exp_last);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
